btn_evt: RTL and testbench
==========================

Name: btn_evt

Overview:
- Downstream consumer of the debounce stage: takes its clean, synchronous, active-high button level and classifies it into single-cycle event pulses (press, release, click, double-click, long-press).
- Sits between the debounced button input and the application logic (LED/mode control) on the 12 MHz icestick clock domain.
- Input is already debounced and synchronous; no synchronizer or filtering inside.

Parameters:
- LONG_COUNT, 12000000, cycles the button must stay held after the press edge to raise long_p (1 s at 12 MHz).
- DBL_COUNT, 3000000, maximum release-gap cycles within which a second press counts as a double-click (250 ms).
- REPEAT_COUNT, 2400000, auto-repeat period in cycles while in HOLD (used only with the optional feature).
- CNT_W, 24, event counter width; must hold max(LONG_COUNT, DBL_COUNT, REPEAT_COUNT).

Ports:
- clk  input  1  system clock, 12 MHz.
- nrst  input  1  reset, asynchronous, active-low.
- in  input  1  debounced button level, 1 = pressed (the debounce block's out).
- press_p  output  1  one-cycle pulse on each accepted press edge.
- rel_p  output  1  one-cycle pulse on each release edge.
- click_p  output  1  one-cycle pulse: single short press confirmed (gap timed out).
- dbl_p  output  1  one-cycle pulse: second press within DBL_COUNT of a short press release.
- long_p  output  1  one-cycle pulse: button held LONG_COUNT cycles.
- held  output  1  level, 1 while in HOLD state.
- repeat_p  output  1  one-cycle auto-repeat pulse (see Optional Feature).

Behaviour:
- Decided: one clock, clk; reset nrst is asynchronous, active-low. While nrst=0: state=ARM, cnt=0, all outputs 0.
- All outputs registered; a pulse is high for exactly one cycle, in the cycle after the clk edge that sampled the triggering condition.
- cnt: CNT_W-bit, cleared on every state transition, else +1 per cycle; never wraps (all states exit before overflow).
- States:
  - ARM: wait for in=0 -> IDLE. A button held through reset release generates no events.
  - IDLE: in=1 -> press_p, -> DOWN.
  - DOWN: in=0 -> rel_p, -> GAP. in=1 and cnt==LONG_COUNT-1 -> long_p, -> HOLD.
  - GAP: in=1 -> press_p + dbl_p, -> DOWN2. in=0 and cnt==DBL_COUNT-1 -> click_p, -> IDLE.
  - DOWN2: in=0 -> rel_p, -> IDLE (no click_p). in=1 and cnt==LONG_COUNT-1 -> long_p, -> HOLD.
  - HOLD: held=1; in=0 -> rel_p, held=0, -> IDLE. No click_p after a long press.
- Simultaneous events: in GAP, a press on the timeout cycle wins (dbl_p, no click_p). In DOWN/DOWN2, a release on the long-threshold cycle wins (rel_p, no long_p).
- Triple press: the third press is a fresh IDLE press (press_p only).
- Reset mid-operation: immediate return to ARM; pending click/dbl/long are discarded.

Optional Feature:
- Macro BTN_EVT_REPEAT_EN.
- Defined: in HOLD, cnt counts from entry and repeat_p pulses each time cnt reaches REPEAT_COUNT-1, then cnt clears. The first repeat comes REPEAT_COUNT cycles after long_p. A release on a repeat cycle wins (rel_p, no repeat_p).
- Undefined: repeat_p is tied 0, REPEAT_COUNT is unused, and the HOLD counter logic is omitted. The port stays present.

Test Plan (LONG_COUNT=8, DBL_COUNT=6, REPEAT_COUNT=4):
- Reset release with in=1 held for 20 cycles, then in=0 -> no pulses at all; next press gives press_p.
- in=1 for 3 cycles, then 0 for 10 -> press_p, rel_p, then click_p exactly 6 cycles after rel_p; dbl_p and long_p stay 0.
- in=1 for 3, 0 for 2, 1 for 3, 0 -> press_p, rel_p, press_p+dbl_p in the same cycle, rel_p; click_p never asserts.
- in=1 for 20 cycles -> press_p, long_p 8 cycles after press_p, held=1 until release, rel_p on release, no click_p. With BTN_EVT_REPEAT_EN: repeat_p at +4 and +8 after long_p.
- Short press, then second press arriving exactly on the gap-timeout cycle -> dbl_p=1, click_p=0.
- Hold in=1, assert nrst=0 for 2 cycles before long_p, release reset with in=1 -> outputs 0, no long_p; the block stays in ARM until in=0.

Source files
------------

// File: rtl/btn_evt.sv
// btn_evt: classifies a debounced, synchronous, active-high button level
// into one-cycle event pulses (press, release, click, double-click,
// long-press) plus a "held" level.
// Optional feature macro: BTN_EVT_REPEAT_EN enables auto-repeat pulses
// on repeat_p while the button is held past the long-press threshold.
// Without the macro, repeat_p is tied low and the hold-state timer is omitted.
module btn_evt #(
  parameter int LONG_COUNT   = 12000000,
  parameter int DBL_COUNT    = 3000000,
  parameter int REPEAT_COUNT = 2400000,
  parameter int CNT_W        = 24
) (
  input  logic clk,
  input  logic nrst,
  input  logic in,
  output logic press_p,
  output logic rel_p,
  output logic click_p,
  output logic dbl_p,
  output logic long_p,
  output logic held,
  output logic repeat_p
);

  typedef enum logic [2:0] {
    ARM   = 3'd0,
    IDLE  = 3'd1,
    DOWN  = 3'd2,
    GAP   = 3'd3,
    DOWN2 = 3'd4,
    HOLD  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_COUNT - 1);

  // Largest count any state has to reach; the counter must be able to hold it.
  localparam longint MAX_COUNT =
    (longint'(LONG_COUNT) > longint'(DBL_COUNT)) ?
      ((longint'(LONG_COUNT) > longint'(REPEAT_COUNT)) ? longint'(LONG_COUNT) : longint'(REPEAT_COUNT)) :
      ((longint'(DBL_COUNT)  > longint'(REPEAT_COUNT)) ? longint'(DBL_COUNT)  : longint'(REPEAT_COUNT));
  localparam longint CNT_SPAN = longint'(1) << CNT_W;

  generate
    if (MAX_COUNT > CNT_SPAN) begin : g_cnt_w_check
      $error("btn_evt: CNT_W too narrow for the configured counts");
    end
  endgenerate

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;

`ifdef BTN_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_COUNT - 1);
  logic repeat_r;
  assign repeat_p = repeat_r;
`else
  assign repeat_p = 1'b0;
`endif

  // Event classifier FSM: state, phase timer and all registered event outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r  <= ARM;
      cnt_r    <= CNT_ZERO;
      press_p  <= 1'b0;
      rel_p    <= 1'b0;
      click_p  <= 1'b0;
      dbl_p    <= 1'b0;
      long_p   <= 1'b0;
      held     <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      repeat_r <= 1'b0;
`endif
    end else begin
      // Pulses drop back to zero unless a transition below raises them.
      press_p  <= 1'b0;
      rel_p    <= 1'b0;
      click_p  <= 1'b0;
      dbl_p    <= 1'b0;
      long_p   <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      repeat_r <= 1'b0;
`endif
      case (state_r)
        ARM: begin
          // A button held through reset release must be let go first.
          cnt_r <= CNT_ZERO;
          if (!in) begin
            state_r <= IDLE;
          end
        end
        IDLE: begin
          cnt_r <= CNT_ZERO;
          if (in) begin
            press_p <= 1'b1;
            state_r <= DOWN;
          end
        end
        DOWN, DOWN2: begin
          // Release beats the long threshold when both land on one cycle.
          if (!in) begin
            rel_p   <= 1'b1;
            cnt_r   <= CNT_ZERO;
            state_r <= (state_r == DOWN) ? GAP : IDLE;
          end else if (cnt_r == LONG_LAST) begin
            long_p  <= 1'b1;
            held    <= 1'b1;
            cnt_r   <= CNT_ZERO;
            state_r <= HOLD;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        GAP: begin
          // A second press on the timeout cycle still counts as a double.
          if (in) begin
            press_p <= 1'b1;
            dbl_p   <= 1'b1;
            cnt_r   <= CNT_ZERO;
            state_r <= DOWN2;
          end else if (cnt_r == DBL_LAST) begin
            click_p <= 1'b1;
            cnt_r   <= CNT_ZERO;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        HOLD: begin
          if (!in) begin
            rel_p   <= 1'b1;
            held    <= 1'b0;
            cnt_r   <= CNT_ZERO;
            state_r <= IDLE;
          end else begin
`ifdef BTN_EVT_REPEAT_EN
            if (cnt_r == REP_LAST) begin
              repeat_r <= 1'b1;
              cnt_r    <= CNT_ZERO;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
`else
            cnt_r <= CNT_ZERO;
`endif
          end
        end
        default: begin
          state_r <= ARM;
          cnt_r   <= CNT_ZERO;
          held    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_evt.sv
// Self-checking bench for btn_evt with small counts (LONG=8, DBL=6, REPEAT=4).
// Table-driven vectors for the basic click/double sequences, hand-written
// corner-case sequences, and randomized runs checked against a timestamp
// based reference model of the event rules.
module tb_btn_evt;

  localparam int LONG_COUNT   = 8;
  localparam int DBL_COUNT    = 6;
  localparam int REPEAT_COUNT = 4;
  localparam int CNT_W        = 8;

  // Output vector layout: {press, rel, click, dbl, long, held, repeat}
  localparam logic [6:0] Z = 7'b0000000;
  localparam logic [6:0] P = 7'b1000000;
  localparam logic [6:0] R = 7'b0100000;
  localparam logic [6:0] C = 7'b0010000;
  localparam logic [6:0] D = 7'b0001000;

  logic clk, nrst, in;
  logic press_p, rel_p, click_p, dbl_p, long_p, held, repeat_p;

  btn_evt #(
    .LONG_COUNT  (LONG_COUNT),
    .DBL_COUNT   (DBL_COUNT),
    .REPEAT_COUNT(REPEAT_COUNT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .in      (in),
    .press_p (press_p),
    .rel_p   (rel_p),
    .click_p (click_p),
    .dbl_p   (dbl_p),
    .long_p  (long_p),
    .held    (held),
    .repeat_p(repeat_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       in;
    logic [6:0] exp;
  } vec_t;

  vec_t tab_click[$];
  vec_t tab_dbl[$];

  int vectors;
  int miscompares;

  // Reference model: timestamps of the last press/release/long edge.
  int   n;
  bit   armed, down, second, long_fired, gap_open;
  int   press_t, rel_t, long_t;
  logic [6:0] m_exp;

  // Observed-pulse counters for the hand sequences.
  int obs_long, obs_click, obs_dbl, obs_press, obs_rep;

  function automatic vec_t mk(input logic v, input logic [6:0] e);
    vec_t r;
    r.in  = v;
    r.exp = e;
    return r;
  endfunction

  task automatic model(input logic v, input logic r);
    m_exp = Z;
    n = n + 1;
    if (!r) begin
      armed = 1'b0; down = 1'b0; second = 1'b0;
      long_fired = 1'b0; gap_open = 1'b0;
    end else if (!armed) begin
      if (!v) armed = 1'b1;
    end else if (down) begin
      if (!v) begin
        m_exp[5] = 1'b1;
        if (!second && !long_fired) begin
          gap_open = 1'b1;
          rel_t = n;
        end
        down = 1'b0;
        long_fired = 1'b0;
      end else if (!long_fired && (n - press_t == LONG_COUNT)) begin
        m_exp[2] = 1'b1;
        long_fired = 1'b1;
        long_t = n;
      end else if (long_fired) begin
`ifdef BTN_EVT_REPEAT_EN
        if (((n - long_t) % REPEAT_COUNT) == 0) m_exp[0] = 1'b1;
`endif
      end
    end else begin
      if (gap_open) begin
        if (v) begin
          m_exp[6] = 1'b1; m_exp[3] = 1'b1;
          down = 1'b1; second = 1'b1; press_t = n; gap_open = 1'b0;
        end else if (n - rel_t == DBL_COUNT) begin
          m_exp[4] = 1'b1;
          gap_open = 1'b0;
        end
      end else if (v) begin
        m_exp[6] = 1'b1;
        down = 1'b1; second = 1'b0; press_t = n;
      end
    end
    m_exp[1] = down && long_fired;
  endtask

  task automatic tick(input logic v, input logic r);
    in   = v;
    nrst = r;
    @(posedge clk);
    model(v, r);
    #1;
    obs_long  += int'(long_p);
    obs_click += int'(click_p);
    obs_dbl   += int'(dbl_p);
    obs_press += int'(press_p);
    obs_rep   += int'(repeat_p);
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {press_p, rel_p, click_p, dbl_p, long_p, held, repeat_p};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%b exp=%b (press,rel,click,dbl,long,held,repeat)",
               name, n, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic clr_obs();
    obs_long = 0; obs_click = 0; obs_dbl = 0; obs_press = 0; obs_rep = 0;
  endtask

  task automatic run(input string name, input logic v, input int len);
    for (int k = 0; k < len; k++) begin
      tick(v, 1'b1);
      check(name, m_exp);
    end
  endtask

  initial begin
    logic v;
    int   len;
    vectors = 0; miscompares = 0; n = 0;
    armed = 1'b0; down = 1'b0; second = 1'b0; long_fired = 1'b0; gap_open = 1'b0;
    press_t = 0; rel_t = 0; long_t = 0;
    clr_obs();

    // Short press then long gap: press, rel, click 6 cycles after rel.
    for (int i = 0; i < 3; i++) tab_click.push_back(mk(1'b1, (i == 0) ? P : Z));
    for (int i = 0; i < 10; i++) tab_click.push_back(mk(1'b0, (i == 0) ? R : ((i == 6) ? C : Z)));
    // Double click: press, rel, press+dbl, rel, no click.
    for (int i = 0; i < 3; i++) tab_dbl.push_back(mk(1'b1, (i == 0) ? P : Z));
    for (int i = 0; i < 2; i++) tab_dbl.push_back(mk(1'b0, (i == 0) ? R : Z));
    for (int i = 0; i < 3; i++) tab_dbl.push_back(mk(1'b1, (i == 0) ? (P | D) : Z));
    for (int i = 0; i < 9; i++) tab_dbl.push_back(mk(1'b0, (i == 0) ? R : Z));

    // Reset state.
    in = 1'b0; nrst = 1'b0;
    tick(1'b0, 1'b0); check("reset0", Z);
    tick(1'b0, 1'b0); check("reset1", Z);
    run("arm", 1'b0, 2);

    foreach (tab_click[i]) begin
      tick(tab_click[i].in, 1'b1);
      check("tbl_click", tab_click[i].exp);
    end
    foreach (tab_dbl[i]) begin
      tick(tab_dbl[i].in, 1'b1);
      check("tbl_dbl", tab_dbl[i].exp);
    end

    // Button held through reset release: nothing until released.
    clr_obs();
    tick(1'b1, 1'b0); check("rst_held", Z);
    tick(1'b1, 1'b0); check("rst_held", Z);
    run("arm_held", 1'b1, 20);
    chk_int("arm_held_press", obs_press, 0);
    chk_int("arm_held_long", obs_long, 0);
    run("arm_rel", 1'b0, 2);
    tick(1'b1, 1'b1); check("arm_first_press", P);
    run("arm_first_press_hold", 1'b1, 2);
    run("arm_first_press_gap", 1'b0, 8);

    // Long press: long 8 cycles after press, held until release, no click.
    clr_obs();
    tick(1'b1, 1'b1); check("long_press", P);
    for (int k = 1; k < 20; k++) begin
      tick(1'b1, 1'b1);
      check("long_hold", m_exp);
      if (k == LONG_COUNT) chk_int("long_at_8", int'(long_p), 1);
    end
    tick(1'b0, 1'b1); check("long_rel", R);
    run("long_after", 1'b0, 10);
    chk_int("long_count", obs_long, 1);
    chk_int("long_no_click", obs_click, 0);
`ifdef BTN_EVT_REPEAT_EN
    chk_int("long_repeats", obs_rep, 2);
`else
    chk_int("long_repeats", obs_rep, 0);
`endif

    // Release exactly on the long-threshold cycle: rel wins, no long.
    clr_obs();
    run("thr_press", 1'b1, LONG_COUNT);
    tick(1'b0, 1'b1); check("thr_rel", R);
    run("thr_gap", 1'b0, 8);
    chk_int("thr_no_long", obs_long, 0);

    // Second press exactly on the gap-timeout cycle: dbl, no click.
    clr_obs();
    run("gto_press", 1'b1, 3);
    run("gto_gap", 1'b0, DBL_COUNT);
    tick(1'b1, 1'b1); check("gto_dbl", P | D);
    run("gto_hold", 1'b1, 2);
    run("gto_rel", 1'b0, 8);
    chk_int("gto_no_click", obs_click, 0);
    chk_int("gto_dbl_cnt", obs_dbl, 1);

    // Triple press: third one is a plain press.
    run("tri_1", 1'b1, 2); run("tri_g1", 1'b0, 2);
    run("tri_2", 1'b1, 2); run("tri_g2", 1'b0, 2);
    tick(1'b1, 1'b1); check("tri_3", P);
    run("tri_3h", 1'b1, 1); run("tri_end", 1'b0, 8);

    // Reset mid-press before long: discarded, stays armed-off until released.
    clr_obs();
    run("mid_press", 1'b1, 5);
    tick(1'b1, 1'b0); check("mid_rst", Z);
    tick(1'b1, 1'b0); check("mid_rst", Z);
    run("mid_held", 1'b1, 15);
    chk_int("mid_no_long", obs_long, 0);
    run("mid_rel", 1'b0, 2);
    tick(1'b1, 1'b1); check("mid_next_press", P);
    run("mid_next_rel", 1'b0, 8);

    // Randomized runs against the reference model.
    for (int i = 0; i < 250; i++) begin
      v   = 1'($urandom_range(0, 1));
      len = v ? $urandom_range(1, 20) : $urandom_range(1, 10);
      if ($urandom_range(0, 24) == 0) begin
        tick(v, 1'b0); check("rand_rst", m_exp);
      end
      run("rand", v, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
